acq_track_ctrl: RTL and testbench
=================================

Name: acq_track_ctrl

Overview:
- Parametrised successor to the fixed 31-chip integrator/detect/control chain of the DSSS receiver.
- Accepts despread I/Q chips from the correlator and coherently integrates them over one code period.
- Non-coherently accumulates energy over DWELL periods and runs a SEARCH/VERIFY/LOCK state machine with loss-of-lock hysteresis.
- Drives shift_parse to the m-code generator for one-chip code-phase slips, and exposes per-period sums for the decoder.

Parameters:
- IW, 2, signed width of I_in/Q_in.
- CODE_LEN, 31, chips per code period (≥2).
- ACC_W, 10, signed coherent accumulator width; must hold CODE_LEN·2^(IW-1).
- DWELL, 1, code periods summed per decision (≥1).
- MISS_MAX, 3, consecutive below-threshold dwells in LOCK before lock is dropped (≥1).
- EW, 20, energy width; ≥ 2·ACC_W + clog2(DWELL).
- PW, 5, phase index width = clog2(CODE_LEN).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, chip strobe; I_in/Q_in are valid when en=1.
- I_in, in, IW, signed despread in-phase chip.
- Q_in, in, IW, signed despread quadrature chip.
- threshold, in, EW, unsigned detection threshold; sampled at the decision edge.
- shift_parse, out, 1, one-cycle pulse: code generator slips one chip.
- sum_I, out, ACC_W, signed coherent sum of the last period.
- sum_Q, out, ACC_W, signed coherent sum of the last period.
- energy, out, EW, sum_I²+sum_Q² of the last period.
- result_ok, out, 1, one-cycle pulse when sum_I/sum_Q/energy update.
- flag, out, 1, 1 while state==LOCK.
- state, out, 2, 0=SEARCH, 1=VERIFY, 2=LOCK.
- phase_idx, out, PW, number of slips issued mod CODE_LEN.
- sweep_done, out, 1, one-cycle pulse when phase_idx wraps CODE_LEN-1→0.

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, state=SEARCH, and all counters, accumulators and the blank tag are cleared.
- Period accumulation:
  - chip_cnt advances on en and wraps at CODE_LEN-1.
  - On the first chip the accumulator loads the sample; on later chips it adds the sample.
  - en=0 freezes all counters.
- Pipeline:
  - Edge E0 (en=1, chip_cnt==CODE_LEN-1): sum_I/sum_Q <= acc + sample.
  - Edge E1: energy <= sum_I²+sum_Q² and result_ok=1 for one cycle.
  - At E1, if the period is not blanked: dwell_sum += energy (saturating at 2^EW-1) and dwell_cnt++.
  - Edge E2 (dwell_cnt reached DWELL): decision hit = dwell_sum ≥ threshold; dwell_sum and dwell_cnt clear.
  - Chips with en=1 during E1/E2 accumulate into the next period normally.
- State machine (decision edge only):
  - SEARCH, hit: go to VERIFY.
  - SEARCH, miss: stay in SEARCH and slip.
  - VERIFY, hit: go to LOCK and clear miss_cnt.
  - VERIFY, miss: go to SEARCH and slip.
  - LOCK, hit: clear miss_cnt.
  - LOCK, miss: miss_cnt++; when miss_cnt reaches MISS_MAX, go to SEARCH, clear miss_cnt and slip.
- Slip:
  - shift_parse=1 for exactly the cycle after E2.
  - phase_idx++; on wrap from CODE_LEN-1 to 0, phase_idx=0 and sweep_done pulses in the same cycle as shift_parse.
  - The period in progress when shift_parse asserts is tagged blank. Its sums and result_ok are still produced, but it is excluded from dwell accumulation. The blank tag clears at that period's E1.
- flag is registered from state: it rises the cycle LOCK is entered and falls the cycle SEARCH is entered.
- Simultaneous events:
  - A decision and a new E0 on the same edge both take effect.
  - threshold changes mid-dwell do not matter; only the value at E2 is used.
- No arithmetic wrap is permitted for legal parameters. Sums are two's complement; energy is unsigned.

Test Plan:
- Reset mid-period (drive rst_n=0 at chip 15) -> all outputs 0 on the next sample; after release, the first result_ok comes 31 chips after the first en.
- en=1 continuous, I_in=+1, Q_in=0, threshold=900, DWELL=1 -> sum_I=31, sum_Q=0, energy=961 at the first result_ok; state 0→1→2 at successive decisions; flag=1; shift_parse never asserts.
- I_in=+1, Q_in=-1, threshold=2000 -> energy=1922 each period; shift_parse pulses once per period; phase_idx counts 0..30; sweep_done pulses on the 31st slip; every period following a slip is blanked (no dwell contribution).
- In LOCK with MISS_MAX=3, switch inputs to alternating ±1 (energy ≤ 2) -> flag holds for 2 misses and drops on the 3rd; shift_parse pulses with the SEARCH entry.
- DWELL=4, I_in=+1, Q_in=0, threshold=3844 -> decision after 4 periods (dwell_sum=3844) yields a hit; with threshold=3845 it is a miss and slips.
- en toggled 1-0-1 every cycle -> sums identical to the continuous case; chip_cnt advances only on en.

Source files
------------

// File: rtl/acq_track_ctrl.sv
// Code-period coherent integrator, dwell energy detector and SEARCH/VERIFY/LOCK
// controller for the DSSS receiver; issues one-chip slips to the m-code generator.
module acq_track_ctrl #(
  parameter int IW       = 2,
  parameter int CODE_LEN = 31,
  parameter int ACC_W    = 10,
  parameter int DWELL    = 1,
  parameter int MISS_MAX = 3,
  parameter int EW       = 20,
  parameter int PW       = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [IW-1:0]    I_in,
  input  logic signed [IW-1:0]    Q_in,
  input  logic        [EW-1:0]    threshold,
  output logic                    shift_parse,
  output logic signed [ACC_W-1:0] sum_I,
  output logic signed [ACC_W-1:0] sum_Q,
  output logic        [EW-1:0]    energy,
  output logic                    result_ok,
  output logic                    flag,
  output logic        [1:0]       state,
  output logic        [PW-1:0]    phase_idx,
  output logic                    sweep_done
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCK   = 2'd2;

  localparam int DW   = $clog2(DWELL + 1);
  localparam int MW   = $clog2(MISS_MAX + 1);
  localparam int SQ_W = 2 * ACC_W;

  localparam logic [PW-1:0] LAST_CHIP  = PW'(CODE_LEN - 1);
  localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL - 1);
  localparam logic [MW-1:0] MISS_LIMIT = MW'(MISS_MAX);

  logic        [PW-1:0]    chip_cnt;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] samp_i, samp_q, acc_i_nxt, acc_q_nxt;
  logic signed [SQ_W-1:0]  wide_i, wide_q;
  logic        [SQ_W-1:0]  sq_i, sq_q;
  logic        [EW-1:0]    energy_nxt;
  logic        [EW:0]      dwell_add;
  logic        [EW-1:0]    dwell_sat;
  logic        [EW-1:0]    dwell_sum;
  logic        [DW-1:0]    dwell_cnt;
  logic        [MW-1:0]    miss_cnt, miss_nxt;
  logic        [1:0]       state_nxt;
  logic                    last_chip, period_end;
  logic                    e1_pend, e2_pend;
  logic                    cur_blank, e1_blank;
  logic                    hit, slip;

  // Size casts of signed operands sign-extend the chips into the accumulator width.
  assign samp_i     = ACC_W'(I_in);
  assign samp_q     = ACC_W'(Q_in);
  assign last_chip  = (chip_cnt == LAST_CHIP);
  assign period_end = en && last_chip;
  assign acc_i_nxt  = (chip_cnt == '0) ? samp_i : acc_i + samp_i;
  assign acc_q_nxt  = (chip_cnt == '0) ? samp_q : acc_q + samp_q;

  assign wide_i     = SQ_W'(sum_I);
  assign wide_q     = SQ_W'(sum_Q);
  assign sq_i       = wide_i * wide_i;
  assign sq_q       = wide_q * wide_q;
  assign energy_nxt = EW'(sq_i) + EW'(sq_q);

  assign dwell_add  = {1'b0, dwell_sum} + {1'b0, energy_nxt};
  assign dwell_sat  = dwell_add[EW] ? '1 : dwell_add[EW-1:0];
  assign hit        = (dwell_sum >= threshold);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt = state;
    miss_nxt  = miss_cnt;
    slip      = 1'b0;
    if (e2_pend) begin
      case (state)
        S_SEARCH: begin
          if (hit) state_nxt = S_VERIFY;
          else     slip      = 1'b1;
        end
        S_VERIFY: begin
          if (hit) begin
            state_nxt = S_LOCK;
            miss_nxt  = '0;
          end else begin
            state_nxt = S_SEARCH;
            slip      = 1'b1;
          end
        end
        S_LOCK: begin
          if (hit) begin
            miss_nxt = '0;
          end else if (miss_cnt + MW'(1) == MISS_LIMIT) begin
            state_nxt = S_SEARCH;
            miss_nxt  = '0;
            slip      = 1'b1;
          end else begin
            miss_nxt = miss_cnt + MW'(1);
          end
        end
        default: state_nxt = S_SEARCH;
      endcase
    end
  end

  // E0 closes a period, E1 squares it, E2 (when the dwell is full) decides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_cnt  <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      sum_I     <= '0;
      sum_Q     <= '0;
      energy    <= '0;
      result_ok <= 1'b0;
      e1_pend   <= 1'b0;
      e2_pend   <= 1'b0;
      e1_blank  <= 1'b0;
      cur_blank <= 1'b0;
      dwell_sum <= '0;
      dwell_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments let every branch below read pre-edge values.
      e1_pend   <= period_end;
      result_ok <= e1_pend;
      e2_pend   <= e1_pend && !e1_blank && (dwell_cnt == LAST_DWELL);
      if (en) begin
        chip_cnt <= last_chip ? '0 : chip_cnt + PW'(1);
        acc_i    <= acc_i_nxt;
        acc_q    <= acc_q_nxt;
      end
      if (period_end) begin
        sum_I <= acc_i_nxt;
        sum_Q <= acc_q_nxt;
      end
      if (e1_pend) begin
        energy   <= energy_nxt;
        e1_blank <= 1'b0;
        if (!e1_blank) begin
          dwell_sum <= dwell_sat;
          dwell_cnt <= dwell_cnt + DW'(1);
        end
      end
      if (e2_pend) begin
        dwell_sum <= '0;
        dwell_cnt <= '0;
      end
      // The blank tag travels with its period: handed to the E1 stage at E0.
      if (period_end) begin
        e1_blank  <= cur_blank;
        cur_blank <= 1'b0;
      end
      if (slip) cur_blank <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_SEARCH;
      miss_cnt    <= '0;
      flag        <= 1'b0;
      shift_parse <= 1'b0;
      sweep_done  <= 1'b0;
      phase_idx   <= '0;
    end else begin
      state       <= state_nxt;
      miss_cnt    <= miss_nxt;
      flag        <= (state_nxt == S_LOCK);
      shift_parse <= slip;
      sweep_done  <= slip && (phase_idx == LAST_CHIP);
      if (slip) phase_idx <= (phase_idx == LAST_CHIP) ? '0 : phase_idx + PW'(1);
    end
  end

endmodule

// File: tb/tb_acq_track_ctrl.sv
// Directed bench for acq_track_ctrl: a DWELL=1 instance for the main sequence and a
// DWELL=4 instance for the dwell-threshold boundary.
module tb_acq_track_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [1:0]  I_in, Q_in;
  logic        [19:0] threshold;
  logic        [21:0] threshold4;

  logic               shift_parse, result_ok, flag, sweep_done;
  logic signed [9:0]  sum_I, sum_Q;
  logic        [19:0] energy;
  logic        [1:0]  state;
  logic        [4:0]  phase_idx;

  logic               shift4, rok4, flag4, sweep4;
  logic signed [9:0]  sum_I4, sum_Q4;
  logic        [21:0] energy4;
  logic        [1:0]  state4;
  logic        [4:0]  phase4;

  int tests = 0, fails = 0, edge_n = 0;
  int n_shift = 0, n_sweep = 0, n_shift4 = 0;

  acq_track_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .I_in(I_in), .Q_in(Q_in),
    .threshold(threshold), .shift_parse(shift_parse), .sum_I(sum_I), .sum_Q(sum_Q),
    .energy(energy), .result_ok(result_ok), .flag(flag), .state(state),
    .phase_idx(phase_idx), .sweep_done(sweep_done)
  );

  acq_track_ctrl #(.DWELL(4), .EW(22)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .I_in(I_in), .Q_in(Q_in),
    .threshold(threshold4), .shift_parse(shift4), .sum_I(sum_I4), .sum_Q(sum_Q4),
    .energy(energy4), .result_ok(rok4), .flag(flag4), .state(state4),
    .phase_idx(phase4), .sweep_done(sweep4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs; outputs are sampled 1 time unit later.
  task automatic step(input logic e, input logic signed [1:0] i, input logic signed [1:0] q);
    en = e; I_in = i; Q_in = q;
    @(posedge clk); #1;
    edge_n++;
    n_shift  += int'(shift_parse);
    n_sweep  += int'(sweep_done);
    n_shift4 += int'(shift4);
  endtask

  task automatic run_to(input int target, input logic signed [1:0] i, input logic signed [1:0] q);
    while (edge_n < target) step(1'b1, i, q);
  endtask

  // Chip for the coming edge: +1 on even edge numbers, -1 on odd ones.
  function automatic logic signed [1:0] alt();
    return (edge_n % 2 == 1) ? 2'sd1 : -2'sd1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    edge_n = 0; n_shift = 0; n_sweep = 0; n_shift4 = 0;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; I_in = '0; Q_in = '0;
    threshold = 20'd900; threshold4 = 22'd3844;
    #2 rst_n = 1'b0;
    #20;
    check("por sum_I", sum_I, 0);
    check("por energy", energy, 0);
    check("por state", state, 0);
    check("por flag", flag, 0);
    check("por result_ok", result_ok, 0);
    check("por shift_parse", shift_parse, 0);
    check("por phase_idx", phase_idx, 0);
    check("por sweep_done", sweep_done, 0);
    rst_n = 1'b1;

    // Reset in the middle of the second period, after the first hit.
    run_to(47, 2'sd1, 2'sd0);
    check("pre-rst state", state, 1);
    check("pre-rst sum_I", sum_I, 31);
    rst_n = 1'b0;
    #1;
    check("mid-rst sum_I", sum_I, 0);
    check("mid-rst energy", energy, 0);
    check("mid-rst state", state, 0);
    #1;
    rst_n = 1'b1;
    edge_n = 0; n_shift = 0; n_sweep = 0; n_shift4 = 0;

    // Strong constant signal: SEARCH -> VERIFY -> LOCK, no slips.
    run_to(31, 2'sd1, 2'sd0);
    check("E0 sum_I", sum_I, 31);
    check("E0 sum_Q", sum_Q, 0);
    check("E0 result_ok", result_ok, 0);
    step(1'b1, 2'sd1, 2'sd0);
    check("E1 result_ok", result_ok, 1);
    check("E1 energy", energy, 961);
    check("E1 state", state, 0);
    step(1'b1, 2'sd1, 2'sd0);
    check("E2 state verify", state, 1);
    check("E2 flag", flag, 0);
    check("E2 result_ok", result_ok, 0);
    run_to(64, 2'sd1, 2'sd0);
    check("lock state", state, 2);
    check("lock flag", flag, 1);
    check("lock no slips", n_shift, 0);

    // Alternating chips: three misses drop the lock.
    while (edge_n < 94) step(1'b1, alt(), 2'sd0);
    check("alt sum_I", sum_I, 1);
    check("alt energy", energy, 1);
    check("alt result_ok", result_ok, 1);
    while (edge_n < 126) step(1'b1, alt(), 2'sd0);
    check("miss2 state", state, 2);
    check("miss2 flag", flag, 1);
    while (edge_n < 157) step(1'b1, alt(), 2'sd0);
    check("miss3 state", state, 0);
    check("miss3 flag", flag, 0);
    check("miss3 shift", shift_parse, 1);
    check("miss3 phase", phase_idx, 1);
    check("miss3 slip count", n_shift, 1);

    // Energy 1922 below 2000: slip every other period because of blanking.
    threshold = 20'd2000;
    step(1'b1, 2'sd1, -2'sd1);
    check("shift one cycle", shift_parse, 0);
    run_to(217, 2'sd1, -2'sd1);
    check("iq sum_I", sum_I, 31);
    check("iq sum_Q", sum_Q, -31);
    step(1'b1, 2'sd1, -2'sd1);
    check("iq energy", energy, 1922);
    check("blank period no slip", n_shift, 1);
    step(1'b1, 2'sd1, -2'sd1);
    check("slip2 shift", shift_parse, 1);
    check("slip2 phase", phase_idx, 2);
    run_to(2016, 2'sd1, -2'sd1);
    check("sweep slip count", n_shift, 30);
    check("sweep phase 30", phase_idx, 30);
    check("sweep none yet", n_sweep, 0);
    step(1'b1, 2'sd1, -2'sd1);
    check("wrap shift", shift_parse, 1);
    check("wrap sweep_done", sweep_done, 1);
    check("wrap phase", phase_idx, 0);

    // Threshold lowered mid-dwell -> hit into VERIFY, then a zero period -> SEARCH.
    run_to(2046, 2'sd1, -2'sd1);
    run_to(2070, 2'sd1, 2'sd0);
    threshold = 20'd900;
    run_to(2077, 2'sd1, 2'sd0);
    step(1'b1, 2'sd0, 2'sd0);
    check("verify energy", energy, 961);
    step(1'b1, 2'sd0, 2'sd0);
    check("verify state", state, 1);
    check("verify no shift", shift_parse, 0);
    run_to(2110, 2'sd0, 2'sd0);
    check("verify miss state", state, 0);
    check("verify miss shift", shift_parse, 1);
    check("verify miss phase", phase_idx, 1);

    // en toggled every cycle; junk on idle cycles must not be accumulated.
    do_reset();
    check("rst2 phase", phase_idx, 0);
    while (edge_n < 60) begin
      if (edge_n % 2 == 0) step(1'b1, 2'sd1, 2'sd0);
      else                 step(1'b0, -2'sd1, -2'sd1);
    end
    check("gated pre sum_I", sum_I, 0);
    check("gated pre result_ok", result_ok, 0);
    step(1'b1, 2'sd1, 2'sd0);
    check("gated sum_I", sum_I, 31);
    check("gated sum_Q", sum_Q, 0);
    step(1'b0, -2'sd1, -2'sd1);
    check("gated result_ok", result_ok, 1);
    check("gated energy", energy, 961);
    step(1'b1, 2'sd1, 2'sd0);
    check("gated state", state, 1);

    // DWELL=4: 4*961 = 3844 against thresholds 3844 (hit) and 3845 (miss).
    do_reset();
    threshold4 = 22'd3844;
    run_to(125, 2'sd1, 2'sd0);
    check("d4 energy", energy4, 961);
    check("d4 pre state", state4, 0);
    check("d4 no slip", n_shift4, 0);
    step(1'b1, 2'sd1, 2'sd0);
    check("d4 hit state", state4, 1);
    threshold4 = 22'd3845;
    run_to(249, 2'sd1, 2'sd0);
    check("d4 hold state", state4, 1);
    step(1'b1, 2'sd1, 2'sd0);
    check("d4 miss state", state4, 0);
    check("d4 miss shift", shift4, 1);
    check("d4 miss phase", phase4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
